data_mem_responder: RTL

//  Multi-cycle data-memory slave that services load/store requests issued by the MEM stage.

---
 rtl/data_mem_responder.sv | 83 ++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle data-memory slave with valid/ready requests and a one-cycle response pulse.
// Defining DMEM_BOUNDS_CHECK_EN adds the resp_err port, suppresses out-of-range stores and zeroes out-of-range load data.
module data_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'd1024,
  parameter int          DEPTH       = 64,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        busy
`ifdef DMEM_BOUNDS_CHECK_EN
  ,
  output logic        resp_err
`endif
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAITING, ACCESS, RESP} state_t;
  state_t         state_q;
  logic [3:0]     cnt_q;
  logic           we_q;
  logic           err_q;
  logic [AW-1:0]  idx_q;
  logic [31:0]    wdata_q;
  logic           resp_valid_q;
  logic [31:0]    resp_rdata_q;
  logic [31:0]    mem_q [DEPTH];
  logic           oor;
`ifdef DMEM_BOUNDS_CHECK_EN
  // The unsigned subtract wraps addresses below BASE_ADDR to huge values, so one compare covers both bounds.
  assign oor      = (req_addr - BASE_ADDR) >= 32'(4 * DEPTH);
  assign resp_err = (state_q == RESP) && err_q;
`else
  assign oor = 1'b0;
`endif
  assign req_ready  = state_q == IDLE;
  assign busy       = !req_ready;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'(i);
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      case (state_q)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          err_q   <= oor;
          idx_q   <= AW'((req_addr - BASE_ADDR) >> 2);
          wdata_q <= req_wdata;
          cnt_q   <= 4'(WAIT_CYCLES);
          state_q <= (WAIT_CYCLES > 0) ? WAITING : ACCESS;
        end
        WAITING: begin
          cnt_q   <= cnt_q - 4'd1;
          state_q <= (cnt_q == 4'd1) ? ACCESS : WAITING;
        end
        ACCESS: begin
          if (we_q && !err_q) mem_q[idx_q] <= wdata_q;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= (we_q || err_q) ? 32'd0 : mem_q[idx_q];
          state_q      <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
